// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared owner/state encodings and arbitration constants
package mem_arbiter_pkg;

    // Which requester owns a memory command or response.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Response FSM: RESP means read data is being returned this cycle.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Memory returns read data this many cycles after acceptance.
    localparam int READ_LATENCY = 1;

    // Starvation counter width and saturation point.
    localparam int STARVE_W = 8;
    localparam logic [STARVE_W-1:0] STARVE_MAX = 8'd255;

    // Data is treated as the previous owner so fetch wins the first contention.
    localparam owner_t RESET_OWNER = OWN_D;

    // Saturating increment for the starvation counters.
    function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
        return (v == STARVE_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and memory command/response bundle
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch port
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    // Data load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    // Shared single-port memory
    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    // Arbiter view
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_addr, m_wdata
    );

    // Requesters and memory view
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// rtl/mem_arbiter_rr_pick2.sv - two-input round-robin selector
module rr_pick2
    import mem_arbiter_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_owner,
    output owner_t sel,
    output logic   req_any
);

    // Lone requester always wins; on contention the one not served last wins.
    always_comb begin
        req_any = req_i | req_d;
        sel     = OWN_I;
        if (req_i && req_d) begin
            sel = (last_owner == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            sel = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto a single-port memory
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    owner_t              last_owner;
    owner_t              rr_sel;
    owner_t              sel;
    owner_t              resp_owner;
    state_t              state;
    state_t              state_next;
    logic                req_any;
    logic                force_i;
    logic                force_d;
    logic                accept;
    logic                is_read;
    logic                gnt_i_raw;
    logic                gnt_d_raw;
    logic                resp_pend;
    logic [STARVE_W-1:0] starve_i;
    logic [STARVE_W-1:0] starve_d;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                cmd_we;

    rr_pick2 u_pick (
        .req_i      (bus.i_req),
        .req_d      (bus.d_req),
        .last_owner (last_owner),
        .sel        (rr_sel),
        .req_any    (req_any)
    );

    // A saturated starve counter overrides round-robin unless both are saturated.
    always_comb begin
        force_i = bus.i_req && (starve_i == STARVE_MAX) &&
                  !(bus.d_req && (starve_d == STARVE_MAX));
        force_d = bus.d_req && (starve_d == STARVE_MAX) &&
                  !(bus.i_req && (starve_i == STARVE_MAX));
        sel = rr_sel;
        if (force_d) begin
            sel = OWN_D;
        end else if (force_i) begin
            sel = OWN_I;
        end
    end

    // Acceptance and command payload; state updates use the ungated view since
    // reset holds every register anyway.
    always_comb begin
        accept    = req_any && bus.m_ready;
        gnt_i_raw = accept && (sel == OWN_I);
        gnt_d_raw = accept && (sel == OWN_D);
        is_read   = (sel == OWN_I) || !bus.d_we;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_we    = 1'b0;
        if (req_any) begin
            if (sel == OWN_I) begin
                cmd_addr = bus.i_addr;
            end else begin
                cmd_addr  = bus.d_addr;
                cmd_wdata = bus.d_wdata;
                cmd_we    = bus.d_we;
            end
        end
    end

    // Response FSM next state: any accepted read produces a response next cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: state_next = (accept && is_read) ? ST_RESP : ST_IDLE;
            ST_RESP: state_next = (accept && is_read) ? ST_RESP : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Response FSM state register; reset discards any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign resp_pend = (state == ST_RESP);

    // Round-robin history and response routing tag, updated on acceptance only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= RESET_OWNER;
            resp_owner <= OWN_I;
        end else if (accept) begin
            last_owner <= sel;
            if (is_read) begin
                resp_owner <= sel;
            end
        end
    end

    // Consecutive requested-but-not-granted cycles per requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_i <= '0;
            starve_d <= '0;
        end else begin
            starve_i <= (gnt_i_raw || !bus.i_req) ? '0 : sat_inc(starve_i);
            starve_d <= (gnt_d_raw || !bus.d_req) ? '0 : sat_inc(starve_d);
        end
    end

    // Port outputs, all forced low while reset is asserted.
    always_comb begin
        bus.m_en     = 1'b0;
        bus.m_we     = 1'b0;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.i_gnt    = 1'b0;
        bus.d_gnt    = 1'b0;
        bus.i_rvalid = 1'b0;
        bus.d_rvalid = 1'b0;
        bus.i_rdata  = '0;
        bus.d_rdata  = '0;
        if (rst_n) begin
            bus.m_en     = req_any;
            bus.m_we     = cmd_we;
            bus.m_addr   = cmd_addr;
            bus.m_wdata  = cmd_wdata;
            bus.i_gnt    = gnt_i_raw;
            bus.d_gnt    = gnt_d_raw;
            bus.i_rvalid = resp_pend && (resp_owner == OWN_I);
            bus.d_rvalid = resp_pend && (resp_owner == OWN_D);
            if (resp_pend && (resp_owner == OWN_I)) begin
                bus.i_rdata = bus.m_rdata;
            end
            if (resp_pend && (resp_owner == OWN_D)) begin
                bus.d_rdata = bus.m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rst_next;
    int   checks;
    int   passed;
    int   ncyc;
    exp_t sb[$];

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_resp();
        exp_t        e;
        logic        iv;
        logic        dv;
        logic [31:0] id;
        logic [31:0] dd;
        iv = 1'b0; dv = 1'b0; id = '0; dd = '0;
        if (sb.size() > 0 && sb[0].due == ncyc) begin
            e = sb.pop_front();
            if (e.owner) begin
                dv = 1'b1; dd = e.data;
            end else begin
                iv = 1'b1; id = e.data;
            end
        end
        chk($sformatf("c%0d.i_rvalid", ncyc), bus.i_rvalid, iv);
        chk($sformatf("c%0d.d_rvalid", ncyc), bus.d_rvalid, dv);
        chk($sformatf("c%0d.i_rdata", ncyc), bus.i_rdata, id);
        chk($sformatf("c%0d.d_rdata", ncyc), bus.d_rdata, dd);
    endtask

    // Advance one clock: the memory model returns data for a read it accepted.
    task automatic cyc();
        logic        acc;
        logic [31:0] a;
        acc = bus.m_en && bus.m_ready && !bus.m_we;
        a   = bus.m_addr;
        @(posedge clk);
        #1;
        if (rst_next) begin
            rst_n    = 1'b0;
            rst_next = 1'b0;
            sb.delete();
        end
        bus.m_rdata = acc ? mem_f(a) : $urandom;
        ncyc++;
        #1;
        check_resp();
    endtask

    task automatic cmd(input string tag, input logic ig, input logic dg, input logic en,
                       input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        #1;
        chk({tag, ".i_gnt"}, bus.i_gnt, ig);
        chk({tag, ".d_gnt"}, bus.d_gnt, dg);
        chk({tag, ".m_en"}, bus.m_en, en);
        chk({tag, ".m_we"}, bus.m_we, we);
        chk({tag, ".m_addr"}, bus.m_addr, addr);
        chk({tag, ".m_wdata"}, bus.m_wdata, wdata);
        if ((ig || dg) && !we) begin
            e.owner = dg;
            e.data  = mem_f(addr);
            e.due   = ncyc + 1;
            sb.push_back(e);
        end
    endtask

    initial begin
        checks = 0; passed = 0; ncyc = 0; rst_next = 1'b0;
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_ready = 1'b1; bus.m_rdata = '0;
        cyc();
        cyc();

        // Reset holds every output low even with requests present
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_wdata = 32'h1234_5678;
        cmd("reset", 0, 0, 0, 0, 32'h0, 32'h0);
        cyc();

        // Contention after reset: fetch first, then alternate
        rst_n = 1'b1;
        cmd("rr0", 1, 0, 1, 0, 32'h40, 32'h0);
        cyc();
        cmd("rr1", 0, 1, 1, 0, 32'h80, 32'h1234_5678);
        cyc();
        cmd("rr2", 1, 0, 1, 0, 32'h40, 32'h0);
        cyc();
        cmd("rr3", 0, 1, 1, 0, 32'h80, 32'h1234_5678);
        cyc();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        cmd("idle0", 0, 0, 0, 0, 32'h0, 32'h0);

        // Store: granted at once, no load response afterwards
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
        cmd("wr", 0, 1, 1, 1, 32'h100, 32'hDEAD_BEEF);
        cyc();
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wdata = '0;
        cmd("idle1", 0, 0, 0, 0, 32'h0, 32'h0);
        cyc();

        // Load stalled by m_ready=0 for three cycles
        bus.d_req = 1'b1; bus.d_addr = 32'h200; bus.m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd($sformatf("stall%0d", k), 0, 0, 1, 0, 32'h200, 32'h0);
            cyc();
        end
        bus.m_ready = 1'b1;
        cmd("stall_go", 0, 1, 1, 0, 32'h200, 32'h0);
        cyc();
        bus.d_req = 1'b0;

        // Back-to-back fetch stream
        bus.i_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.i_addr = 32'(k * 4);
            cmd($sformatf("fetch%0d", k), 1, 0, 1, 0, 32'(k * 4), 32'h0);
            cyc();
        end
        bus.i_req = 1'b0;
        cmd("idle2", 0, 0, 0, 0, 32'h0, 32'h0);
        cyc();

        // Reset asserted the cycle after an accepted read drops the response
        bus.i_req = 1'b1; bus.i_addr = 32'h300;
        cmd("pre_rst", 1, 0, 1, 0, 32'h300, 32'h0);
        rst_next = 1'b1;
        cyc();
        bus.d_req = 1'b1; bus.d_addr = 32'h80;
        cmd("in_rst0", 0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        cmd("in_rst1", 0, 0, 0, 0, 32'h0, 32'h0);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        rst_n = 1'b1;
        cmd("post_rst", 0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        cyc();
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        cmd("post_rst_rr", 1, 0, 1, 0, 32'h300, 32'h0);
        cyc();
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        cyc();

        // Starvation: data last served, then held off long enough to saturate
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h400; bus.d_wdata = 32'hCAFE_F00D;
        cmd("sv_wr", 0, 1, 1, 1, 32'h400, 32'hCAFE_F00D);
        cyc();
        bus.d_we = 1'b0; bus.d_addr = 32'h500; bus.d_wdata = '0; bus.m_ready = 1'b0;
        for (int k = 0; k < 260; k++) begin
            cyc();
        end
        cmd("sv_hold", 0, 0, 1, 0, 32'h500, 32'h0);
        bus.i_req = 1'b1; bus.i_addr = 32'h600;
        cmd("sv_force", 0, 0, 1, 0, 32'h500, 32'h0);
        cyc();
        bus.m_ready = 1'b1;
        cmd("sv_gnt", 0, 1, 1, 0, 32'h500, 32'h0);
        cyc();
        bus.d_req = 1'b0;
        cmd("sv_i", 1, 0, 1, 0, 32'h600, 32'h0);
        cyc();
        bus.i_req = 1'b0;
        cyc();
        chk("sb_empty", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
